// File: rtl/alu_pkg.sv
// Shared definitions for the mini ALU: function codes, default width and the
// BIST driver state encoding.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 6;

  localparam logic [2:0] FXN_PASS_A = 3'b000;
  localparam logic [2:0] FXN_PASS_B = 3'b001;
  localparam logic [2:0] FXN_NEG_A  = 3'b010;
  localparam logic [2:0] FXN_NEG_B  = 3'b011;
  localparam logic [2:0] FXN_SLT    = 3'b100;
  localparam logic [2:0] FXN_XNOR   = 3'b101;
  localparam logic [2:0] FXN_ADD    = 3'b110;
  localparam logic [2:0] FXN_SUB    = 3'b111;

  localparam logic [2:0] FXN_LAST   = FXN_SUB;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } bist_state_t;

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference for the mini ALU: maps (A, B, fxn) to the result
// the datapath must produce, all arithmetic mod 2^WIDTH.
module alu_golden_model
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_fxn,
  output logic [WIDTH-1:0] o_expected
);

  logic w_lt;

  assign w_lt = ($signed(i_a) < $signed(i_b));

  always_comb begin
    o_expected = '0;
    case (i_fxn)
      FXN_PASS_A: o_expected = i_a;
      FXN_PASS_B: o_expected = i_b;
      FXN_NEG_A:  o_expected = -i_a;
      FXN_NEG_B:  o_expected = -i_b;
      FXN_SLT:    o_expected = {{(WIDTH-1){1'b0}}, w_lt};
      FXN_XNOR:   o_expected = ~(i_a ^ i_b);
      FXN_ADD:    o_expected = i_a + i_b;
      FXN_SUB:    o_expected = i_a - i_b;
      default:    o_expected = '0;
    endcase
  end

endmodule

// File: rtl/alu_bist_driver.sv
// Built-in self-test initiator for the mini ALU: sweeps every function code
// over NUM_VEC operand pairs, checks X against the golden model and keeps score.
module alu_bist_driver
  import alu_pkg::*;
#(
  parameter  int          WIDTH   = DEFAULT_WIDTH,
  parameter  int          NUM_VEC = 4,
  parameter  int unsigned STRIDE  = 1,
  parameter  int          SETTLE  = 2,
  localparam int          CNT_W   = $clog2(8*NUM_VEC+1)
)(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [2:0]       o_alu_fxn,
  input  logic [WIDTH-1:0] i_alu_x,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pass_count,
  output logic [CNT_W-1:0] o_total_count,
  output logic             o_fail_seen,
  output logic [2:0]       o_fail_fxn,
  output logic [WIDTH-1:0] o_fail_a,
  output logic [WIDTH-1:0] o_fail_b,
  output logic [WIDTH-1:0] o_fail_x
);

  localparam int OP_W  = 2*WIDTH;
  localparam int IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int SET_W = (SETTLE  > 1) ? $clog2(SETTLE)  : 1;

  localparam logic [OP_W-1:0]  STEP     = OP_W'(STRIDE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VEC-1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE-1);

  bist_state_t      r_state;
  bist_state_t      w_next_state;

  logic [SET_W-1:0] r_settle;
  logic [IDX_W-1:0] r_idx;
  logic [2:0]       r_fxn;
  logic [OP_W-1:0]  r_ops;

  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_total;
  logic             r_fail_seen;
  logic [2:0]       r_fail_fxn;
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_b;
  logic [WIDTH-1:0] r_fail_x;

  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_expected;
  logic             w_match;
  logic             w_launch;
  logic             w_settle_last;
  logic             w_idx_last;
  logic             w_last_vec;

  assign w_op_a        = r_ops[OP_W-1:WIDTH];
  assign w_op_b        = r_ops[WIDTH-1:0];
  assign w_match       = (i_alu_x == w_expected);
  assign w_launch      = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_settle_last = (r_settle == SET_LAST);
  assign w_idx_last    = (r_idx == IDX_LAST);
  assign w_last_vec    = w_idx_last && (r_fxn == FXN_LAST);

  alu_golden_model #(
    .WIDTH (WIDTH)
  ) u_golden (
    .i_a        (w_op_a),
    .i_b        (w_op_b),
    .i_fxn      (r_fxn),
    .o_expected (w_expected)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next_state = ST_DRIVE;
      end
      ST_DRIVE: begin
        o_busy = 1'b1;
        if (w_settle_last) w_next_state = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        o_busy       = 1'b1;
        w_next_state = w_last_vec ? ST_DONE : ST_DRIVE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (i_start) w_next_state = ST_DRIVE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Vector sequencing: index is the inner loop, fxn the outer; the operand
  // counter restarts from zero for every function code.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_settle <= '0;
      r_idx    <= '0;
      r_fxn    <= '0;
      r_ops    <= '0;
    end else if (w_launch) begin
      r_settle <= '0;
      r_idx    <= '0;
      r_fxn    <= '0;
      r_ops    <= '0;
    end else if (r_state == ST_DRIVE) begin
      r_settle <= w_settle_last ? '0 : r_settle + SET_W'(1);
    end else if ((r_state == ST_SAMPLE) && !w_last_vec) begin
      if (w_idx_last) begin
        r_idx <= '0;
        r_ops <= '0;
        r_fxn <= r_fxn + 3'd1;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
        r_ops <= r_ops + STEP;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pass  <= '0;
      r_total <= '0;
    end else if (w_launch) begin
      r_pass  <= '0;
      r_total <= '0;
    end else if (r_state == ST_SAMPLE) begin
      r_total <= r_total + CNT_W'(1);
      if (w_match) r_pass <= r_pass + CNT_W'(1);
    end
  end

  // Only the first mismatch of a run is kept so the report points at the
  // earliest failing vector.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fail_seen <= 1'b0;
      r_fail_fxn  <= '0;
      r_fail_a    <= '0;
      r_fail_b    <= '0;
      r_fail_x    <= '0;
    end else if (w_launch) begin
      r_fail_seen <= 1'b0;
      r_fail_fxn  <= '0;
      r_fail_a    <= '0;
      r_fail_b    <= '0;
      r_fail_x    <= '0;
    end else if ((r_state == ST_SAMPLE) && !w_match && !r_fail_seen) begin
      r_fail_seen <= 1'b1;
      r_fail_fxn  <= r_fxn;
      r_fail_a    <= w_op_a;
      r_fail_b    <= w_op_b;
      r_fail_x    <= i_alu_x;
    end
  end

  assign o_alu_a       = w_op_a;
  assign o_alu_b       = w_op_b;
  assign o_alu_fxn     = r_fxn;
  assign o_pass_count  = r_pass;
  assign o_total_count = r_total;
  assign o_fail_seen   = r_fail_seen;
  assign o_fail_fxn    = r_fail_fxn;
  assign o_fail_a      = r_fail_a;
  assign o_fail_b      = r_fail_b;
  assign o_fail_x      = r_fail_x;

endmodule

// File: tb/tb_alu_bist_driver.sv
// Bench for alu_bist_driver: two instances (default and strided) driven against
// an ALU stub with injectable faults, checked against a vector-list model.
module tb_alu_bist_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  always #5 clk = ~clk;

  logic [5:0] a0, b0, x0, fa0, fb0, fx0, pass0, total0;
  logic [2:0] f0, ffxn0;
  logic       busy0, done0, seen0;

  logic [5:0] a1, b1, x1, fa1, fb1, fx1;
  logic [4:0] pass1, total1;
  logic [2:0] f1, ffxn1;
  logic       busy1, done1, seen1;

  int checks = 0;
  int failures = 0;

  bit         corrupt [8][64];
  logic [5:0] xpat [8];
  bit         saw_e38;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [5:0] pass;
    logic [5:0] total;
    logic       seen;
    logic [2:0] ffxn;
    logic [5:0] fa;
    logic [5:0] fb;
    logic [5:0] fx;
  } obs_t;

  alu_bist_driver dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0),
    .o_alu_a(a0), .o_alu_b(b0), .o_alu_fxn(f0), .i_alu_x(x0),
    .o_busy(busy0), .o_done(done0),
    .o_pass_count(pass0), .o_total_count(total0),
    .o_fail_seen(seen0), .o_fail_fxn(ffxn0),
    .o_fail_a(fa0), .o_fail_b(fb0), .o_fail_x(fx0)
  );

  alu_bist_driver #(.NUM_VEC(2), .STRIDE('hE38)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1),
    .o_alu_a(a1), .o_alu_b(b1), .o_alu_fxn(f1), .i_alu_x(x1),
    .o_busy(busy1), .o_done(done1),
    .o_pass_count(pass1), .o_total_count(total1),
    .o_fail_seen(seen1), .o_fail_fxn(ffxn1),
    .o_fail_a(fa1), .o_fail_b(fb1), .o_fail_x(fx1)
  );

  // Correct 6-bit ALU behaviour, written with plain integer arithmetic.
  function automatic int good_x(int a, int b, int f);
    int sa, sb;
    sa = (a >= 32) ? a - 64 : a;
    sb = (b >= 32) ? b - 64 : b;
    case (f)
      0: return a;
      1: return b;
      2: return (64 - a) % 64;
      3: return (64 - b) % 64;
      4: return (sa < sb) ? 1 : 0;
      5: return 63 - (a ^ b);
      6: return (a + b) % 64;
      default: return (a - b + 64) % 64;
    endcase
  endfunction

  function automatic int stub_x(int a, int b, int f);
    return good_x(a, b, f) ^ (corrupt[f][b] ? int'(xpat[f]) : 0);
  endfunction

  always @(negedge clk) begin
    x0 = 6'(stub_x(int'(a0), int'(b0), int'(f0)));
    x1 = 6'(stub_x(int'(a1), int'(b1), int'(f1)));
    if (busy1 && a1 == 6'd56 && b1 == 6'd56) saw_e38 = 1'b1;
  end

  function automatic obs_t get_obs(int sel);
    obs_t o;
    if (sel == 0) o = '{busy0, done0, pass0, total0, seen0, ffxn0, fa0, fb0, fx0};
    else          o = '{busy1, done1, {1'b0, pass1}, {1'b0, total1}, seen1, ffxn1, fa1, fb1, fx1};
    return o;
  endfunction

  // Expected end-of-run state: walk the vector list in order and score each
  // stub response against the correct ALU result.
  task automatic model_run(input int nv, input int stride, output obs_t e);
    int cnt, a, b, x;
    e = '0;
    e.done = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < nv; i++) begin
        cnt = (i * stride) % 4096;
        a = cnt / 64;
        b = cnt % 64;
        x = stub_x(a, b, f);
        e.total = e.total + 6'd1;
        if (x == good_x(a, b, f)) e.pass = e.pass + 6'd1;
        else if (!e.seen) begin
          e.seen = 1'b1;
          e.ffxn = 3'(f);
          e.fa = 6'(a);
          e.fb = 6'(b);
          e.fx = 6'(x);
        end
      end
    end
  endtask

  task automatic clear_faults();
    foreach (corrupt[f, b]) corrupt[f][b] = 1'b0;
    foreach (xpat[f]) xpat[f] = 6'd0;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  task automatic run_dut(input int sel, input int inject_at, output int busy_cyc,
                         output bit finished, output obs_t first);
    obs_t o;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    first = get_obs(sel);
    busy_cyc = 0;
    finished = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      o = get_obs(sel);
      if (o.done) begin
        finished = 1'b1;
        break;
      end
      if (o.busy) busy_cyc++;
      set_start(sel, n == inject_at);
      @(negedge clk);
    end
    set_start(sel, 1'b0);
  endtask

  task automatic test_reset();
    obs_t o;
    #2 rst_n = 1'b0;
    #1;
    o = get_obs(0);
    checks++;
    if (o !== '0) begin failures++; $display("FAIL reset_obs0: got %h expected 0", o); end
    checks++;
    if ({a0, b0, f0} !== 15'd0) begin failures++; $display("FAIL reset_ops0: got %h expected 0", {a0, b0, f0}); end
    o = get_obs(1);
    checks++;
    if (o !== '0) begin failures++; $display("FAIL reset_obs1: got %h expected 0", o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_good_run();
    obs_t o, e, first;
    int bc;
    bit fin;
    clear_faults();
    run_dut(0, -1, bc, fin, first);
    model_run(4, 1, e);
    o = get_obs(0);
    checks++;
    if (!fin) begin failures++; $display("FAIL good_timeout: done=%b required 1", o.done); end
    checks++;
    if (bc != 96) begin failures++; $display("FAIL good_busy_cycles: got %0d expected 96", bc); end
    checks++;
    if (o !== e) begin failures++; $display("FAIL good_result: got %h expected %h", o, e); end
    checks++;
    if (o.pass !== 6'd32) begin failures++; $display("FAIL good_pass: got %0d expected 32", o.pass); end
  endtask

  task automatic test_lsb_fault();
    obs_t o, e, first;
    int bc;
    bit fin;
    clear_faults();
    for (int b = 0; b < 64; b++) corrupt[6][b] = 1'b1;
    xpat[6] = 6'd1;
    run_dut(0, -1, bc, fin, first);
    model_run(4, 1, e);
    o = get_obs(0);
    checks++;
    if (!fin) begin failures++; $display("FAIL lsb_timeout: done=%b required 1", o.done); end
    checks++;
    if (o !== e) begin failures++; $display("FAIL lsb_result: got %h expected %h", o, e); end
    checks++;
    if ({o.pass, o.seen, o.ffxn, o.fa, o.fb, o.fx} !== {6'd28, 1'b1, 3'b110, 6'd0, 6'd0, 6'd1})
      begin failures++; $display("FAIL lsb_capture: got %h expected %h",
        {o.pass, o.seen, o.ffxn, o.fa, o.fb, o.fx}, {6'd28, 1'b1, 3'b110, 6'd0, 6'd0, 6'd1}); end
  endtask

  task automatic test_random_faults();
    obs_t o, e, first;
    int bc;
    bit fin;
    for (int it = 0; it < 6; it++) begin
      int sel = (it < 4) ? 0 : 1;
      clear_faults();
      foreach (corrupt[f, b]) corrupt[f][b] = ($urandom_range(0, 5) == 0);
      foreach (xpat[f]) xpat[f] = 6'($urandom_range(1, 63));
      run_dut(sel, -1, bc, fin, first);
      if (sel == 0) model_run(4, 1, e);
      else          model_run(2, 'hE38, e);
      o = get_obs(sel);
      checks++;
      if (!fin || bc != ((sel == 0) ? 96 : 48)) begin
        failures++; $display("FAIL rand_timing_%0d: busy=%0d done=%b", it, bc, fin); end
      checks++;
      if (o !== e) begin failures++; $display("FAIL rand_result_%0d: got %h expected %h", it, o, e); end
    end
  endtask

  task automatic test_stride();
    obs_t o, e, first;
    int bc;
    bit fin;
    clear_faults();
    saw_e38 = 1'b0;
    run_dut(1, -1, bc, fin, first);
    model_run(2, 'hE38, e);
    o = get_obs(1);
    checks++;
    if (!fin || bc != 48) begin failures++; $display("FAIL stride_timing: busy=%0d done=%b expected 48/1", bc, fin); end
    checks++;
    if (o !== e) begin failures++; $display("FAIL stride_result: got %h expected %h", o, e); end
    checks++;
    if ({o.pass, o.total, o.seen} !== {6'd16, 6'd16, 1'b0}) begin
      failures++; $display("FAIL stride_counts: pass=%0d total=%0d seen=%b expected 16 16 0", o.pass, o.total, o.seen); end
    checks++;
    if (!saw_e38) begin failures++; $display("FAIL stride_vector1: operands 111000 never driven, got 0 expected 1"); end
  endtask

  task automatic test_ignored_start();
    obs_t o, e, first;
    int bc;
    bit fin;
    clear_faults();
    xpat[3] = 6'h2A;
    corrupt[3][2] = 1'b1;
    run_dut(0, 10, bc, fin, first);
    model_run(4, 1, e);
    o = get_obs(0);
    checks++;
    if (!fin || bc != 96) begin failures++; $display("FAIL ignore_timing: busy=%0d done=%b expected 96/1", bc, fin); end
    checks++;
    if (o !== e) begin failures++; $display("FAIL ignore_result: got %h expected %h", o, e); end
  endtask

  task automatic test_reset_midrun();
    obs_t o, e, first;
    int bc;
    bit fin;
    clear_faults();
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (39) @(negedge clk);
    rst_n = 1'b0;
    #1;
    o = get_obs(0);
    checks++;
    if (o !== '0 || {a0, b0, f0} !== 15'd0) begin
      failures++; $display("FAIL midrun_async: got %h ops %h expected 0", o, {a0, b0, f0}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    o = get_obs(0);
    checks++;
    if (o !== '0) begin failures++; $display("FAIL midrun_idle: got %h expected 0", o); end
    run_dut(0, -1, bc, fin, first);
    model_run(4, 1, e);
    o = get_obs(0);
    checks++;
    if (!fin || o !== e || o.total !== 6'd32) begin
      failures++; $display("FAIL midrun_rerun: got %h expected %h done=%b", o, e, fin); end
  endtask

  task automatic test_back_to_back();
    obs_t o, e, first, efirst;
    int bc;
    bit fin;
    clear_faults();
    corrupt[7][1] = 1'b1;
    xpat[7] = 6'h10;
    run_dut(0, -1, bc, fin, first);
    run_dut(0, -1, bc, fin, first);
    efirst = '0;
    efirst.busy = 1'b1;
    checks++;
    if (first !== efirst) begin failures++; $display("FAIL b2b_restart: got %h expected %h", first, efirst); end
    model_run(4, 1, e);
    o = get_obs(0);
    checks++;
    if (!fin || bc != 96) begin failures++; $display("FAIL b2b_timing: busy=%0d done=%b expected 96/1", bc, fin); end
    checks++;
    if (o !== e) begin failures++; $display("FAIL b2b_result: got %h expected %h", o, e); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_faults();
    saw_e38 = 1'b0;
    test_reset();
    test_good_run();
    test_lsb_fault();
    test_stride();
    test_random_faults();
    test_ignored_start();
    test_reset_midrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_bist_driver.md
Name: alu_bist_driver

Overview:
- Built-in self-test initiator for the 6-bit mini ALU datapath (ports A, B, fxn in; X out).
- Drives operand pairs and function codes into the ALU, waits a settle window, then samples X.
- Compares X against an internal golden model and accumulates pass/total counts plus first-failure capture.
- Lets the board-level design self-check the ALU on hardware without the simulation bench.

Parameters:
- WIDTH, 6, operand/result width in bits.
- NUM_VEC, 4, operand vectors applied per function code (>=1).
- STRIDE, 1, increment of the 2*WIDTH-bit operand counter per vector (taken mod 2^(2*WIDTH)).
- SETTLE, 2, cycles operands are held before sampling X (>=1).
- Derived localparam CNT_W = clog2(8*NUM_VEC+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request.
- alu_a  out  WIDTH  to ALU A.
- alu_b  out  WIDTH  to ALU B.
- alu_fxn  out  3  to ALU fxn.
- alu_x  in  WIDTH  from ALU X.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start.
- pass_count  out  CNT_W  vectors matched.
- total_count  out  CNT_W  vectors sampled.
- fail_seen  out  1  at least one mismatch this run.
- fail_fxn  out  3  fxn of the first mismatch.
- fail_a  out  WIDTH  A of the first mismatch.
- fail_b  out  WIDTH  B of the first mismatch.
- fail_x  out  WIDTH  X of the first mismatch.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset state: all outputs 0, FSM in IDLE, operand counter 0. This also applies when reset is asserted mid-run; the run is discarded and no partial done is produced.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE, start=1:
  - clear counts, fail_seen and fail_* registers.
  - set fxn=0, vector index=0, operand counter=0.
  - go to DRIVE. busy=1 and done=0 from the next cycle.
- DRIVE:
  - alu_a = counter[2W-1:W], alu_b = counter[W-1:0], alu_fxn = fxn. All are registered and stable for the whole state.
  - Stay SETTLE cycles, then go to SAMPLE.
- SAMPLE (one cycle):
  - total_count += 1.
  - If alu_x == expected, pass_count += 1.
  - Otherwise, if fail_seen==0, capture fxn, A, B and X into fail_*, then set fail_seen=1.
  - If this was the last vector (fxn==7 and index==NUM_VEC-1), go to DONE.
  - Otherwise advance and go back to DRIVE.
  - Operands stay held through SAMPLE.
- Advance order: inner loop is the vector index. Each step adds STRIDE to the operand counter, wrapping at 2^(2W). At index==NUM_VEC-1 the index returns to 0, the counter resets to 0, and fxn increments.
- DONE: busy=0, done=1, counts frozen, operands keep their last values.
- start while busy is ignored.
- start in DONE restarts the run with all state cleared.
- Run latency: start edge to done = 8*NUM_VEC*(SETTLE+1)+1 cycles. Default: 97.
- Golden model (expected), mod 2^W, two's complement:
  - 000 A
  - 001 B
  - 010 -A
  - 011 -B
  - 100 signed(A)<signed(B) ? 1 : 0, zero-extended to W bits
  - 101 ~(A^B)
  - 110 A+B
  - 111 A-B

Decomposition:
- Shared package alu_pkg holds:
  - fxn code localparams FXN_PASS_A, FXN_PASS_B, FXN_NEG_A, FXN_NEG_B, FXN_SLT, FXN_XNOR, FXN_ADD, FXN_SUB.
  - the FSM state encoding.
  - default WIDTH=6.
- Sub-module alu_golden_model: purely combinational (A, B, fxn -> expected), instantiated once. It is reusable by the ALU bench.

Test Plan:
- Default parameters, known-good ALU attached, start pulse -> busy for 96 cycles, then done=1, pass_count=32, total_count=32, fail_seen=0.
- ALU stub with X LSB inverted for fxn=110 only -> pass_count=28, total_count=32, fail_seen=1, fail_fxn=110, fail_a=000000, fail_b=000000, fail_x=000001.
- STRIDE=12'hE38, NUM_VEC=2 -> vector 1 drives A=B=111000. Expected responses:
  - fxn=110: X=110000.
  - fxn=100: X=000000.
  - fxn=010: X=001000.
  - all 16 pass.
- Start pulse issued at cycle 10 of a run -> ignored. Counts at done are identical to the uninterrupted run; done appears at cycle 97.
- rst_n low for 1 cycle mid-run (cycle 40), then a new start:
  - during reset: all outputs 0 immediately (async).
  - after the new start: the fresh run completes with total_count=32.
- Second start while in DONE -> done drops the next cycle, counts clear to 0, the run repeats with the same results.
